data_pack: RTL and testbench
============================

# data_pack

Transmit-side bit packer that sits directly upstream of the data unpacker. It accepts a stream of 7-bit symbols over a valid/ready handshake and packs them LSB-first, with no gaps, into 32-bit words. It emits those words over a second valid/ready handshake, in the same format the unpacker consumes. A flush request closes out a partial word as a zero-padded final word flagged with `word_last`.

## Interface
Parameters:
- `SYM_W`, 7, symbol width in bits; must be less than `WORD_W`.
- `WORD_W`, 32, output word width in bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sym_in`  in  SYM_W  symbol to pack.
- `sym_valid`  in  1  `sym_in` is valid.
- `sym_ready`  out  1  the block accepts `sym_in` this cycle.
- `flush`  in  1  single-cycle request to emit the pending partial word.
- `word_out`  out  WORD_W  packed word; held stable while `word_valid && !word_ready`.
- `word_valid`  out  1  `word_out` is valid.
- `word_ready`  in  1  downstream accepts `word_out`.
- `word_last`  out  1  qualifies `word_out` as a flush-generated word.
- `fill`  out  5  number of accumulated, unemitted bits (0..31).

## Operation
- **Bit order.** Symbol bit 0 is placed at accumulator bit `fill`.
  - A symbol that straddles a word boundary puts its low `32-fill` bits in bits `fill..31` of the current word.
  - Its remaining high bits go to bits `0..` of the next word.
- **State.**
  - `acc[31:0]` holds the partial word; bits at or above `fill` are always zero.
  - `fill` is a 5-bit count.
  - Output register: `word_out`, `word_valid`, `word_last`.
  - `flush_pend` flag.
- **FSM states.**
  - RUN: normal packing.
  - FLUSH: `flush_pend`=1, waiting for the output slot.
- **Output slot free** means `!word_valid || word_ready`.
- **`sym_ready`** = `!flush_pend && (slot free || fill+7 < 32)`.
  - This is combinational; it never depends on `sym_valid`.
- **Accept** (`sym_valid && sym_ready`): let `n = fill + 7` (6-bit arithmetic).
  - If `n < 32`:
    - `acc |= sym << fill`.
    - `fill <= n`.
  - If `n >= 32`:
    - `word_out <= acc | (sym << fill)` (low 32 bits).
    - `word_valid <= 1`, `word_last <= 0`.
    - `acc <= sym >> (32 - fill)`.
    - `fill <= n - 32` (range 0..6).
- **Drain.** When `word_ready && word_valid` and no new word is loaded, `word_valid <= 0`.
- **Flush request.** `flush`=1 in RUN sets `flush_pend` and moves to FLUSH.
  - A symbol accepted in the same cycle is packed before the flush takes effect.
- **FLUSH state**, when the slot is free:
  - If `fill != 0`:
    - `word_out <= acc`, `word_valid <= 1`, `word_last <= 1`.
    - `acc <= 0`, `fill <= 0`.
  - If `fill == 0`: no word is emitted.
  - In both cases, clear `flush_pend` and return to RUN.
- `flush` asserted while already in FLUSH is ignored.

## Timing
- **Reset values:**
  - `acc`=0, `fill`=0.
  - `word_out`=0, `word_valid`=0, `word_last`=0.
  - `flush_pend`=0, state RUN.
  - `sym_ready`=1 in the first cycle after reset.
- **Word latency.** A completing symbol accepted at edge N gives `word_valid`=1 from edge N through at least one cycle.
- **Flush latency.**
  - With a free slot, `flush` at edge N gives the last word valid after edge N+1.
  - Otherwise the last word appears one edge after the slot frees.
- **Throughput.** One symbol per cycle is sustained with `word_ready`=1. At most one word is produced per accepted symbol, so no internal queue is needed.
- **Backpressure.**
  - With `word_valid`=1 and `word_ready`=0, symbols are still accepted while `fill+7 < 32`.
  - The symbol that would complete a word stalls (`sym_ready`=0).
- **Simultaneous drain and load** in one cycle: the new word replaces the old one, and `word_valid` stays 1.
- **Reset mid-operation** discards the partial word, the pending output and the pending flush; no partial word is emitted.
- **Wrap.** After 32 accepted symbols (224 bits = 7 words), `fill` returns to its starting value.

## Test plan
- **Pack and flush.**
  - Stimulus: after reset, with `word_ready`=1, send symbols 0x01, 0x02, 0x03, 0x04, 0x7F, then pulse `flush`.
  - Expected:
    - Word 0xF080C101 with `last`=0.
    - `fill`=3.
    - Word 0x00000007 with `last`=1.
    - `fill`=0.
- **Streaming.**
  - Stimulus: send 32 symbols of 0x7F back-to-back.
  - Expected: exactly 7 words of 0xFFFFFFFF, no stall cycles, and `fill`=0 at the end.
- **Backpressure.**
  - Stimulus: hold `word_ready`=0 and stream 0x7F symbols.
  - Expected:
    - The first word appears after 5 symbols, with `fill`=3.
    - Symbols 6–9 are accepted (`fill`=10, 17, 24, 31).
    - `sym_ready`=0 at `fill`=31.
    - `word_out` is held stable throughout.
  - Then raise `word_ready`: the stalled symbol is accepted in the same cycle as the drain, the second word 0xFFFFFFFF is loaded with `word_valid` remaining 1, and `fill`=6.
- **Empty flush and same-cycle flush.**
  - Stimulus: `flush` with `fill`=0.
  - Expected: no word emitted, and `sym_ready` low for exactly one cycle.
  - Stimulus: `flush` in the same cycle as accepting a symbol at `fill`=0.
  - Expected: word 0x0000007F (for symbol 0x7F) with `last`=1.
- **Reset mid-operation.**
  - Stimulus: assert `rst` with `fill`=17 and `word_valid`=1.
  - Expected: all outputs at reset values on the next cycle. Then symbol 0x55 followed by `flush` yields 0x00000055 with `last`=1.

Source files
------------

// File: rtl/data_pack.sv
// data_pack: packs a stream of SYM_W-bit symbols LSB-first into WORD_W-bit words,
// with a flush that emits the pending partial word zero-padded and flagged last.
module data_pack #(
    parameter int SYM_W  = 7,
    parameter int WORD_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SYM_W-1:0]           sym_in,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    input  logic                       flush,
    output logic [WORD_W-1:0]          word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       word_last,
    output logic [$clog2(WORD_W)-1:0]  fill
);
    localparam int FW = $clog2(WORD_W);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;
    localparam logic [FW:0] WW = (FW+1)'(WORD_W);

    logic [0:0]          state;
    logic [WORD_W-1:0]   acc;
    logic [2*WORD_W-1:0] ext;
    logic [FW:0]         n;
    logic                slot_free, fits, accept;

    // ext's upper half is the spill of a symbol straddling the word boundary
    always_comb begin
        ext       = {{(2*WORD_W-SYM_W){1'b0}}, sym_in} << fill;
        n         = {1'b0, fill} + (FW+1)'(SYM_W);
        slot_free = !word_valid || word_ready;
        fits      = n < WW;
        sym_ready = (state == RUN) && (slot_free || fits);
        accept    = sym_valid && sym_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            acc        <= '0;
            fill       <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
        end else begin
            if (word_valid && word_ready)
                word_valid <= 1'b0;
            if (accept) begin
                if (fits) begin
                    acc  <= acc | ext[WORD_W-1:0];
                    fill <= n[FW-1:0];
                end else begin
                    word_out   <= acc | ext[WORD_W-1:0];
                    word_valid <= 1'b1;
                    word_last  <= 1'b0;
                    acc        <= ext[2*WORD_W-1:WORD_W];
                    fill       <= FW'(n - WW);
                end
            end
            // no symbol is accepted while in FLUSH, so this never collides with the load above
            if (state == FLUSH && slot_free) begin
                if (fill != '0) begin
                    word_out   <= acc;
                    word_valid <= 1'b1;
                    word_last  <= 1'b1;
                    acc        <= '0;
                    fill       <= '0;
                end
                state <= RUN;
            end else if (state == RUN && flush) begin
                state <= FLUSH;
            end
        end
    end
endmodule

// File: tb/tb_data_pack.sv
// tb_data_pack: directed scenarios plus a randomized run against a bit-queue model.
module tb_data_pack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  sym_in = '0;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic        flush = 1'b0;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        word_last;
    logic [4:0]  fill;

    int passed = 0;
    int total = 0;
    logic [31:0] got_w[$];
    logic        got_l[$];

    typedef struct {
        logic [31:0] w;
        logic        l;
    } wrd_t;

    data_pack dut (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .flush(flush), .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .word_last(word_last), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic tick;
        #1;
        if (word_valid && word_ready) begin
            got_w.push_back(word_out);
            got_l.push_back(word_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        sym_valid = 1'b0;
        flush = 1'b0;
        tick();
        rst = 1'b0;
        got_w.delete();
        got_l.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++;
        if ({word_valid, word_last, fill, word_out} !== 39'd0)
            $display("FAIL reset_regs: got valid=%b last=%b fill=%0d word=%h want all zero", word_valid, word_last, fill, word_out);
        else passed++;
        total++;
        if (sym_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", sym_ready);
        else passed++;
    endtask

    task automatic test_pack_flush;
        logic [6:0] syms[5] = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h7F};
        do_reset();
        word_ready = 1'b1;
        foreach (syms[i]) begin
            sym_in = syms[i];
            sym_valid = 1'b1;
            tick();
        end
        sym_valid = 1'b0;
        total++;
        if ({word_valid, word_last, word_out} !== {2'b10, 32'hF080C101})
            $display("FAIL pf_word: got v=%b l=%b %h want v=1 l=0 f080c101", word_valid, word_last, word_out);
        else passed++;
        total++;
        if (fill !== 5'd3) $display("FAIL pf_fill3: got %0d want 3", fill);
        else passed++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        total++;
        if ({word_valid, word_last, word_out} !== {2'b11, 32'h00000007})
            $display("FAIL pf_last: got v=%b l=%b %h want v=1 l=1 00000007", word_valid, word_last, word_out);
        else passed++;
        total++;
        if (fill !== 5'd0) $display("FAIL pf_fill0: got %0d want 0", fill);
        else passed++;
    endtask

    task automatic test_streaming;
        int stalls = 0;
        int ok = 1;
        do_reset();
        word_ready = 1'b1;
        sym_in = 7'h7F;
        sym_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            if (!sym_ready) stalls++;
            tick();
        end
        sym_valid = 1'b0;
        tick();
        tick();
        total++;
        if (stalls !== 0) $display("FAIL st_stalls: got %0d want 0", stalls);
        else passed++;
        foreach (got_w[i]) if (got_w[i] !== 32'hFFFFFFFF || got_l[i] !== 1'b0) ok = 0;
        total++;
        if (got_w.size() !== 7 || ok !== 1) $display("FAIL st_words: got %0d words allok=%0d want 7 of ffffffff", got_w.size(), ok);
        else passed++;
        total++;
        if (fill !== 5'd0) $display("FAIL st_fill: got %0d want 0", fill);
        else passed++;
    endtask

    task automatic test_backpressure;
        logic [4:0] exp_fill[4] = '{5'd10, 5'd17, 5'd24, 5'd31};
        logic [31:0] first;
        do_reset();
        word_ready = 1'b0;
        sym_in = 7'h7F;
        sym_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if ({word_valid, word_out, fill} !== {1'b1, 32'hFFFFFFFF, 5'd3})
            $display("FAIL bp_first: got v=%b %h fill=%0d want v=1 ffffffff fill=3", word_valid, word_out, fill);
        else passed++;
        first = word_out;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (fill !== exp_fill[i] || word_out !== first || word_valid !== 1'b1)
                $display("FAIL bp_fill%0d: got fill=%0d v=%b %h want fill=%0d held word", i, fill, word_valid, word_out, exp_fill[i]);
            else passed++;
        end
        total++;
        if (sym_ready !== 1'b0) $display("FAIL bp_stall: got sym_ready=%b want 0", sym_ready);
        else passed++;
        tick();
        total++;
        if (fill !== 5'd31 || word_out !== first) $display("FAIL bp_hold: got fill=%0d %h want 31 held", fill, word_out);
        else passed++;
        word_ready = 1'b1;
        #1;
        total++;
        if (sym_ready !== 1'b1) $display("FAIL bp_release: got sym_ready=%b want 1", sym_ready);
        else passed++;
        tick();
        sym_valid = 1'b0;
        total++;
        if ({word_valid, word_out, fill, got_w.size()} !== {1'b1, 32'hFFFFFFFF, 5'd6, 32'd1})
            $display("FAIL bp_second: got v=%b %h fill=%0d drained=%0d want v=1 ffffffff fill=6 drained=1", word_valid, word_out, fill, got_w.size());
        else passed++;
    endtask

    task automatic test_empty_flush;
        int low = 0;
        do_reset();
        word_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!sym_ready) low++;
            tick();
        end
        total++;
        if (low !== 1) $display("FAIL ef_ready_low: got %0d cycles want 1", low);
        else passed++;
        total++;
        if (got_w.size() !== 0 || word_valid !== 1'b0) $display("FAIL ef_noword: got %0d words v=%b want 0", got_w.size(), word_valid);
        else passed++;
    endtask

    task automatic test_same_cycle_flush;
        do_reset();
        word_ready = 1'b1;
        sym_in = 7'h7F;
        sym_valid = 1'b1;
        flush = 1'b1;
        tick();
        sym_valid = 1'b0;
        flush = 1'b0;
        total++;
        if (fill !== 5'd7) $display("FAIL sf_fill: got %0d want 7", fill);
        else passed++;
        tick();
        total++;
        if ({word_valid, word_last, word_out, fill} !== {2'b11, 32'h0000007F, 5'd0})
            $display("FAIL sf_word: got v=%b l=%b %h fill=%0d want v=1 l=1 0000007f fill=0", word_valid, word_last, word_out, fill);
        else passed++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        word_ready = 1'b0;
        sym_in = 7'h7F;
        sym_valid = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        sym_valid = 1'b0;
        total++;
        if (fill !== 5'd17 || word_valid !== 1'b1) $display("FAIL rm_pre: got fill=%0d v=%b want 17 1", fill, word_valid);
        else passed++;
        flush = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        total++;
        if ({word_valid, word_last, fill, word_out, sym_ready} !== 40'd1)
            $display("FAIL rm_regs: got v=%b l=%b fill=%0d %h rdy=%b want zeros rdy=1", word_valid, word_last, fill, word_out, sym_ready);
        else passed++;
        word_ready = 1'b1;
        sym_in = 7'h55;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        total++;
        if ({word_valid, word_last, word_out} !== {2'b11, 32'h00000055})
            $display("FAIL rm_word: got v=%b l=%b %h want v=1 l=1 00000055", word_valid, word_last, word_out);
        else passed++;
    endtask

    task automatic test_random;
        bit   mq[$];
        wrd_t outq[$];
        bit   mflush = 0;
        int   err = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic exp_rdy, sf;
            wrd_t nw;
            sym_in = 7'($urandom);
            sym_valid = ($urandom_range(3) != 0);
            word_ready = ($urandom_range(1) != 0);
            flush = ($urandom_range(15) == 0);
            #1;
            sf = (outq.size() == 0) || word_ready;
            exp_rdy = !mflush && (sf || mq.size() + 7 < 32);
            total++;
            if (sym_ready !== exp_rdy) begin
                $display("FAIL rnd_ready c=%0d: got %b want %b", c, sym_ready, exp_rdy);
                err++;
            end else passed++;
            total++;
            if (fill !== 5'(mq.size()) || word_valid !== (outq.size() != 0)) begin
                $display("FAIL rnd_state c=%0d: got fill=%0d v=%b want fill=%0d v=%b", c, fill, word_valid, mq.size(), outq.size() != 0);
                err++;
            end else passed++;
            if (outq.size() != 0) begin
                total++;
                if (word_out !== outq[0].w || word_last !== outq[0].l) begin
                    $display("FAIL rnd_word c=%0d: got %h l=%b want %h l=%b", c, word_out, word_last, outq[0].w, outq[0].l);
                    err++;
                end else passed++;
                if (word_ready) void'(outq.pop_front());
            end
            if (sym_valid && exp_rdy) begin
                for (int b = 0; b < 7; b++) mq.push_back(sym_in[b]);
                if (mq.size() >= 32) begin
                    nw.w = '0;
                    nw.l = 1'b0;
                    for (int b = 0; b < 32; b++) nw.w[b] = mq.pop_front();
                    outq.push_back(nw);
                end
            end
            if (mflush && sf) begin
                if (mq.size() != 0) begin
                    nw.w = '0;
                    nw.l = 1'b1;
                    for (int b = 0; mq.size() != 0; b++) nw.w[b] = mq.pop_front();
                    outq.push_back(nw);
                end
                mflush = 0;
            end else if (!mflush && flush) mflush = 1;
            @(posedge clk);
            #1;
            if (err > 20) break;
        end
        sym_valid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pack_flush();
        test_streaming();
        test_backpressure();
        test_empty_flush();
        test_same_cycle_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
